vrf_wb_seq: RTL and testbench
=============================

Name: vrf_wb_seq

Overview:
- Write-back sequencer on the producer side of the VRF write port.
- Accepts complete result vectors (one element per lane) from the lane datapath into a small FIFO.
- Serializes each vector into the VRF's single-element write protocol: wr_req pulse, then one element per cycle with element index, data and per-element enable, then wr_ready to close the transaction.
- Also provides a RAW-hazard lookup so issue logic can stall operand reads of registers with pending writes.

Parameters:
- DATA_WIDTH, 32, element width in bits
- REG_NUM, 32, number of vector registers; ADDR_B = $clog2(REG_NUM)
- LANES, 4, elements per vector; ELEM_B = $clog2(LANES)
- BUF_DEPTH, 2, result FIFO entries, power of two, >= 1

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- res_valid_i  in  1  result vector valid
- res_ready_o  out  1  FIFO can accept; asserted iff FIFO not full
- res_addr_i  in  ADDR_B  destination vector register
- res_data_i  in  LANES*DATA_WIDTH  element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- res_mask_i  in  LANES  per-element write enable (1 = write)
- wr_addr_o  out  ADDR_B  VRF write address
- wr_req_o  out  1  one-cycle write-transaction request
- wr_en_o  out  1  current element is written
- wr_elem_cnt_o  out  ELEM_B  current element index
- wdata_o  out  DATA_WIDTH  current element data
- wr_ready_o  out  1  last element of the transaction; VRF returns to idle
- chk_addr_i  in  ADDR_B  register to test for a pending write
- hazard_o  out  1  chk_addr_i matches any FIFO entry or the active transaction
- busy_o  out  1  FIFO not empty or FSM not IDLE

Behaviour:
- Reset: all outputs 0 except res_ready_o=1; FIFO empty; FSM IDLE; counters 0. A reset asserted mid-transaction aborts it immediately; the partial vector is dropped and no further wr_en_o is issued.
- FIFO:
  - Push on res_valid_i && res_ready_o.
  - Pop when FSM leaves IDLE or LAST for REQ; the popped entry moves into the active register (addr, data, mask).
  - Pointers wrap modulo BUF_DEPTH; a count register gives full/empty.
  - Simultaneous push and pop when full is not possible (res_ready_o=0). Simultaneous push and pop otherwise leaves the count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty -> REQ.
  - REQ: wr_req_o=1, wr_addr_o=active addr; -> WRITE, element counter = 0.
  - WRITE: per cycle, wr_elem_cnt_o=cnt, wdata_o=active data[cnt], wr_en_o=active mask[cnt]. When cnt==LANES-1, wr_ready_o=1 -> LAST; else cnt+1.
  - LAST: one bubble cycle, all strobes 0. If FIFO non-empty -> REQ with pop; else -> IDLE.
- wr_addr_o is held stable from REQ through the wr_ready_o cycle.
- wr_en_o, wr_req_o and wr_ready_o are 0 in every other state.
- Latency: a vector pushed at cycle T into an empty FIFO with FSM in IDLE gives:
  - REQ at T+2 (IDLE sees non-empty at T+1),
  - elements at T+3..T+2+LANES,
  - wr_ready_o at T+2+LANES.
- Back-to-back vectors: LANES+2 cycles per vector (REQ + LANES + LAST).
- All-zero mask: the transaction still runs its full length with wr_en_o=0, so VRF FSM sequencing is preserved.
- hazard_o is combinational. It compares chk_addr_i against valid FIFO entries, plus the active addr when the FSM is in REQ, WRITE or LAST. An entry pushed this cycle is not visible until the next cycle.
- Outputs toward the VRF are registered, or decoded from registered state and counter only; there is no combinational path from res_* to wr_*.

Test Plan:
- Single vector: push addr=5, data={0x44,0x33,0x22,0x11}, mask=4'b1111 at T -> wr_req_o at T+2; wr_en_o=1 with (cnt,wdata) = (0,0x11), (1,0x22), (2,0x33), (3,0x44) over T+3..T+6; wr_ready_o=1 at T+6 only; busy_o=0 from T+8.
- Masked write: mask=4'b0101 -> wr_en_o high only at cnt 0 and 2; the transaction still spans 4 element cycles and ends with wr_ready_o.
- Backpressure: push 3 vectors on consecutive cycles with BUF_DEPTH=2 -> res_ready_o drops once the FIFO holds 2 entries and rises after the first pop. All 3 vectors are written in order, wr_req_o pulses 6 cycles apart.
- Hazard: vector to addr=7 pending -> hazard_o=1 for chk_addr_i=7 through its LAST cycle, 0 afterwards; hazard_o=0 for chk_addr_i=8 throughout.
- Reset mid-transaction: assert rst_i during WRITE cnt=1 -> all wr_* go 0 immediately, res_ready_o=1, busy_o=0. After release, a new vector is written normally from cnt=0.
- Wrap-around: push/pop 5 vectors interleaved so the FIFO pointers wrap twice -> data and addresses emerge in push order with no duplication or loss.

Source files
------------

// File: rtl/vrf_wb_seq_if.sv
// Bundles the result-vector input, VRF write port and hazard lookup of the
// write-back sequencer. The slave modport is the sequencer's view.
interface vrf_wb_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4
);
  localparam int ADDR_B = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int ELEM_B = (LANES > 1) ? $clog2(LANES) : 1;

  logic                        res_valid_i;
  logic                        res_ready_o;
  logic [ADDR_B-1:0]           res_addr_i;
  logic [LANES*DATA_WIDTH-1:0] res_data_i;
  logic [LANES-1:0]            res_mask_i;
  logic [ADDR_B-1:0]           wr_addr_o;
  logic                        wr_req_o;
  logic                        wr_en_o;
  logic [ELEM_B-1:0]           wr_elem_cnt_o;
  logic [DATA_WIDTH-1:0]       wdata_o;
  logic                        wr_ready_o;
  logic [ADDR_B-1:0]           chk_addr_i;
  logic                        hazard_o;
  logic                        busy_o;

  modport slave (
    input  res_valid_i, res_addr_i, res_data_i, res_mask_i, chk_addr_i,
    output res_ready_o, wr_addr_o, wr_req_o, wr_en_o, wr_elem_cnt_o,
           wdata_o, wr_ready_o, hazard_o, busy_o
  );

  modport master (
    output res_valid_i, res_addr_i, res_data_i, res_mask_i, chk_addr_i,
    input  res_ready_o, wr_addr_o, wr_req_o, wr_en_o, wr_elem_cnt_o,
           wdata_o, wr_ready_o, hazard_o, busy_o
  );
endinterface

// File: rtl/vrf_wb_seq.sv
// Write-back sequencer: buffers whole result vectors in a small FIFO and
// replays each one element per cycle on the VRF single-element write port.
// Also answers RAW-hazard lookups for registers that still have writes pending.
module vrf_wb_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  vrf_wb_seq_if.slave   bus
);
  localparam int ADDR_B = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int ELEM_B = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_B  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam logic [ELEM_B-1:0] LAST_IDX = ELEM_B'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, LAST} state_e;

  // FIFO storage and bookkeeping
  logic [ADDR_B-1:0]                 addr_mem_q [BUF_DEPTH];
  logic [ADDR_B-1:0]                 addr_mem_d [BUF_DEPTH];
  logic [LANES-1:0][DATA_WIDTH-1:0]  data_mem_q [BUF_DEPTH];
  logic [LANES-1:0][DATA_WIDTH-1:0]  data_mem_d [BUF_DEPTH];
  logic [LANES-1:0]                  mask_mem_q [BUF_DEPTH];
  logic [LANES-1:0]                  mask_mem_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]              vld_q, vld_d;
  logic [PTR_B-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PTR_B-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                  count_q, count_d;

  // Sequencer state, active vector and registered VRF-side outputs
  state_e                            state_q, state_d;
  logic [ELEM_B-1:0]                 cnt_q, cnt_d;
  logic [ADDR_B-1:0]                 act_addr_q, act_addr_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]  act_data_q, act_data_d;
  logic [LANES-1:0]                  act_mask_q, act_mask_d;
  logic [ADDR_B-1:0]                 wr_addr_q, wr_addr_d;
  logic                              wr_req_q, wr_req_d;
  logic                              wr_en_q, wr_en_d;
  logic [ELEM_B-1:0]                 wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
  logic                              wr_ready_q, wr_ready_d;

  logic push;
  logic pop;
  logic res_ready;
  logic hazard;

  function automatic logic [PTR_B-1:0] ptr_inc(input logic [PTR_B-1:0] p);
    ptr_inc = (p == PTR_B'(BUF_DEPTH - 1)) ? '0 : p + PTR_B'(1);
  endfunction

  assign res_ready = (count_q != CNT_W'(BUF_DEPTH));
  assign push      = bus.res_valid_i && res_ready;
  assign pop       = ((state_q == IDLE) || (state_q == LAST)) && (count_q != '0);

  // FIFO next-state: write at the tail on push, retire the head on pop
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    mask_mem_d = mask_mem_q;
    vld_d      = vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = bus.res_addr_i;
      data_mem_d[wr_ptr_q] = bus.res_data_i;
      mask_mem_d[wr_ptr_q] = bus.res_mask_i;
      vld_d[wr_ptr_q]      = 1'b1;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
      count_d              = count_d + CNT_W'(1);
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
      count_d         = count_d - CNT_W'(1);
    end
  end

  // FIFO registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
        mask_mem_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      mask_mem_q <= mask_mem_d;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Sequencer next-state; VRF outputs are decoded from the next state so
  // they can be registered and never see the res_* inputs combinationally
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_addr_d = act_addr_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    case (state_q)
      IDLE, LAST: begin
        if (pop) begin
          state_d    = REQ;
          act_addr_d = addr_mem_q[rd_ptr_q];
          act_data_d = data_mem_q[rd_ptr_q];
          act_mask_d = mask_mem_q[rd_ptr_q];
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d = WRITE;
        cnt_d   = '0;
      end
      WRITE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = LAST;
        end else begin
          cnt_d = cnt_q + ELEM_B'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_addr_d  = '0;
    wr_req_d   = 1'b0;
    wr_en_d    = 1'b0;
    wr_cnt_d   = '0;
    wdata_d    = '0;
    wr_ready_d = 1'b0;
    if ((state_d == REQ) || (state_d == WRITE)) begin
      wr_addr_d = act_addr_d;
    end
    if (state_d == REQ) begin
      wr_req_d = 1'b1;
    end
    if (state_d == WRITE) begin
      wr_en_d    = act_mask_d[cnt_d];
      wr_cnt_d   = cnt_d;
      wdata_d    = act_data_d[cnt_d];
      wr_ready_d = (cnt_d == LAST_IDX);
    end
  end

  // Sequencer registers; reset drops any partially written vector at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_addr_q <= '0;
      act_data_q <= '0;
      act_mask_q <= '0;
      wr_addr_q  <= '0;
      wr_req_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_cnt_q   <= '0;
      wdata_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_addr_q <= act_addr_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      wr_addr_q  <= wr_addr_d;
      wr_req_q   <= wr_req_d;
      wr_en_q    <= wr_en_d;
      wr_cnt_q   <= wr_cnt_d;
      wdata_q    <= wdata_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Hazard lookup over buffered entries plus the vector being written out
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (vld_q[i] && (addr_mem_q[i] == bus.chk_addr_i)) begin
        hazard = 1'b1;
      end
    end
    if ((state_q != IDLE) && (act_addr_q == bus.chk_addr_i)) begin
      hazard = 1'b1;
    end
  end

  assign bus.res_ready_o   = res_ready;
  assign bus.wr_addr_o     = wr_addr_q;
  assign bus.wr_req_o      = wr_req_q;
  assign bus.wr_en_o       = wr_en_q;
  assign bus.wr_elem_cnt_o = wr_cnt_q;
  assign bus.wdata_o       = wdata_q;
  assign bus.wr_ready_o    = wr_ready_q;
  assign bus.hazard_o      = hazard;
  assign bus.busy_o        = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_vrf_wb_seq.sv
// Directed bench for the write-back sequencer: single, masked, back-to-back,
// hazard, mid-transaction reset and FIFO wrap-around scenarios.
module tb_vrf_wb_seq;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int LN = 4;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   numChecks = 0;
  int   numFails = 0;

  vrf_wb_seq_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN)) bus ();

  vrf_wb_seq #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN), .BUF_DEPTH(BD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Free-running cycle index used to measure request spacing
  always @(posedge clk) cycle <= cycle + 1;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for space, then presents one vector for exactly one cycle
  task automatic applyStimulus(input logic [4:0] addr, input logic [127:0] data, input logic [3:0] mask);
    int waitCnt = 0;
    while (bus.res_ready_o !== 1'b1 && waitCnt < 60) begin
      nextCycle;
      waitCnt++;
    end
    if (waitCnt >= 60) begin
      checkOutput("push_timeout", 128'd0, 128'd1);
      return;
    end
    bus.res_valid_i = 1'b1;
    bus.res_addr_i  = addr;
    bus.res_data_i  = data;
    bus.res_mask_i  = mask;
    nextCycle;
    bus.res_valid_i = 1'b0;
  endtask

  // Waits for the next wr_req pulse and checks the whole transaction
  task automatic expectTxn(input string tag, input logic [4:0] addr, input logic [127:0] data,
                           input logic [3:0] mask, output int reqCycle);
    int waitCnt = 0;
    reqCycle = -1;
    while (bus.wr_req_o !== 1'b1 && waitCnt < 60) begin
      nextCycle;
      waitCnt++;
    end
    if (waitCnt >= 60) begin
      checkOutput({tag, "_req_timeout"}, 128'd0, 128'd1);
      return;
    end
    reqCycle = cycle;
    checkOutput({tag, "_req_addr"}, bus.wr_addr_o, addr);
    checkOutput({tag, "_req_en"}, bus.wr_en_o, 1'b0);
    for (int i = 0; i < LN; i++) begin
      nextCycle;
      checkOutput($sformatf("%s_e%0d_cnt", tag, i), bus.wr_elem_cnt_o, i[1:0]);
      checkOutput($sformatf("%s_e%0d_data", tag, i), bus.wdata_o, data[i*DW +: DW]);
      checkOutput($sformatf("%s_e%0d_en", tag, i), bus.wr_en_o, mask[i]);
      checkOutput($sformatf("%s_e%0d_rdy", tag, i), bus.wr_ready_o, (i == LN - 1));
      checkOutput($sformatf("%s_e%0d_addr", tag, i), bus.wr_addr_o, addr);
      checkOutput($sformatf("%s_e%0d_req", tag, i), bus.wr_req_o, 1'b0);
    end
    nextCycle;
    checkOutput({tag, "_last_en"}, bus.wr_en_o, 1'b0);
    checkOutput({tag, "_last_rdy"}, bus.wr_ready_o, 1'b0);
    checkOutput({tag, "_last_req"}, bus.wr_req_o, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int waitCnt = 0;
    while (bus.busy_o !== 1'b0 && waitCnt < 60) begin
      nextCycle;
      waitCnt++;
    end
    checkOutput({tag, "_idle"}, bus.busy_o, 1'b0);
  endtask

  function automatic logic [127:0] mkData(input int k);
    logic [127:0] d;
    for (int i = 0; i < LN; i++) d[i*DW +: DW] = 32'hA000_0000 | (k << 8) | i;
    return d;
  endfunction

  initial begin
    int r0, r1, r2, t0, dummy;
    logic [127:0] d1, d2, d3;

    rst             = 1'b1;
    bus.res_valid_i = 1'b0;
    bus.res_addr_i  = '0;
    bus.res_data_i  = '0;
    bus.res_mask_i  = '0;
    bus.chk_addr_i  = '0;
    repeat (2) nextCycle;

    // Reset state
    checkOutput("rst_ready", bus.res_ready_o, 1'b1);
    checkOutput("rst_req", bus.wr_req_o, 1'b0);
    checkOutput("rst_en", bus.wr_en_o, 1'b0);
    checkOutput("rst_rdy", bus.wr_ready_o, 1'b0);
    checkOutput("rst_busy", bus.busy_o, 1'b0);
    checkOutput("rst_hazard", bus.hazard_o, 1'b0);
    checkOutput("rst_addr", bus.wr_addr_o, 5'd0);
    rst = 1'b0;
    nextCycle;

    // Single vector with exact latency
    $display("[TB] single vector");
    d1 = 128'h00000044_00000033_00000022_00000011;
    bus.res_valid_i = 1'b1;
    bus.res_addr_i  = 5'd5;
    bus.res_data_i  = d1;
    bus.res_mask_i  = 4'b1111;
    t0 = cycle;
    nextCycle;
    bus.res_valid_i = 1'b0;
    checkOutput("s_t1_req", bus.wr_req_o, 1'b0);
    checkOutput("s_t1_busy", bus.busy_o, 1'b1);
    nextCycle;
    checkOutput("s_t2_req", bus.wr_req_o, 1'b1);
    expectTxn("single", 5'd5, d1, 4'b1111, r0);
    checkOutput("s_req_latency", r0 - t0, 2);
    checkOutput("s_t7_busy", bus.busy_o, 1'b1);
    nextCycle;
    checkOutput("s_t8_busy", bus.busy_o, 1'b0);

    // Masked write
    $display("[TB] masked write");
    d2 = 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001;
    applyStimulus(5'd3, d2, 4'b0101);
    expectTxn("mask", 5'd3, d2, 4'b0101, dummy);
    waitIdle("mask");

    // Back-to-back with backpressure
    $display("[TB] backpressure");
    t0 = cycle;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("bp_ready%0d", k), bus.res_ready_o, 1'b1);
          bus.res_valid_i = 1'b1;
          bus.res_addr_i  = 5'(20 + k);
          bus.res_data_i  = mkData(k + 1);
          bus.res_mask_i  = 4'b1111;
          nextCycle;
        end
        bus.res_valid_i = 1'b0;
        checkOutput("bp_full", bus.res_ready_o, 1'b0);
        repeat (4) nextCycle;
        checkOutput("bp_still_full", bus.res_ready_o, 1'b0);
        nextCycle;
        checkOutput("bp_reopen", bus.res_ready_o, 1'b1);
      end
      begin
        expectTxn("bp0", 5'd20, mkData(1), 4'b1111, r0);
        expectTxn("bp1", 5'd21, mkData(2), 4'b1111, r1);
        expectTxn("bp2", 5'd22, mkData(3), 4'b1111, r2);
      end
    join
    checkOutput("bp_first_lat", r0 - t0, 2);
    checkOutput("bp_gap01", r1 - r0, 6);
    checkOutput("bp_gap12", r2 - r1, 6);
    waitIdle("bp");

    // Hazard lookup
    $display("[TB] hazard");
    bus.res_valid_i = 1'b1;
    bus.res_addr_i  = 5'd7;
    bus.res_data_i  = mkData(9);
    bus.res_mask_i  = 4'b1111;
    bus.chk_addr_i  = 5'd7;
    #1;
    checkOutput("hz_push_cycle", bus.hazard_o, 1'b0);
    nextCycle;
    bus.res_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.chk_addr_i = 5'd7;
      #1;
      checkOutput($sformatf("hz7_t%0d", k), bus.hazard_o, (k <= 7));
      bus.chk_addr_i = 5'd8;
      #1;
      checkOutput($sformatf("hz8_t%0d", k), bus.hazard_o, 1'b0);
      if (k < 8) nextCycle;
    end
    waitIdle("hz");

    // Reset in the middle of a transaction
    $display("[TB] reset mid-transaction");
    applyStimulus(5'd9, mkData(4), 4'b1111);
    repeat (3) nextCycle;
    checkOutput("mr_cnt1", bus.wr_elem_cnt_o, 2'd1);
    checkOutput("mr_en1", bus.wr_en_o, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mr_en", bus.wr_en_o, 1'b0);
    checkOutput("mr_req", bus.wr_req_o, 1'b0);
    checkOutput("mr_rdy", bus.wr_ready_o, 1'b0);
    checkOutput("mr_cnt", bus.wr_elem_cnt_o, 2'd0);
    checkOutput("mr_wdata", bus.wdata_o, 32'd0);
    checkOutput("mr_ready", bus.res_ready_o, 1'b1);
    checkOutput("mr_busy", bus.busy_o, 1'b0);
    nextCycle;
    rst = 1'b0;
    nextCycle;
    checkOutput("mr_post_en", bus.wr_en_o, 1'b0);
    d3 = 128'h0000BBB3_0000BBB2_0000BBB1_0000BBB0;
    applyStimulus(5'd10, d3, 4'b1111);
    expectTxn("mr_new", 5'd10, d3, 4'b1111, dummy);
    waitIdle("mr");

    // Wrap-around: five vectors through a two-entry FIFO
    $display("[TB] wrap-around");
    fork
      begin
        for (int k = 0; k < 5; k++) applyStimulus(5'(k + 11), mkData(k + 16), 4'hF ^ 4'(k));
      end
      begin
        for (int k = 0; k < 5; k++)
          expectTxn($sformatf("wrap%0d", k), 5'(k + 11), mkData(k + 16), 4'hF ^ 4'(k), dummy);
      end
    join
    waitIdle("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
    $finish;
  end
endmodule
